// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage core: sequences the multi-cycle mult/div
// unit from X and stalls on load-use hazards that forwarding cannot resolve.
module hazard_stall_ctrl #(
    parameter int MAX_MD_CYCLES = 40,
    parameter int CNT_W         = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] irFD,
    input  logic [31:0] irDX,
    input  logic        multdivReady,
    input  logic        multdivException,
    output logic        pcEn,
    output logic        fdEn,
    output logic        dxEn,
    output logic        dxNop,
    output logic        xmNop,
    output logic        ctrlMult,
    output logic        ctrlDiv,
    output logic        xmSelMultdiv,
    output logic        mdExc,
    output logic        mdBusy
);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_MD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_exc;
    logic             w_exc_nxt;

    logic [4:0] w_dx_op, w_dx_rd, w_dx_alu;
    logic [4:0] w_fd_op, w_fd_rd, w_fd_rs, w_fd_rt;
    logic       w_dx_mul, w_dx_div, w_dx_md;
    logic       w_load_use;
    logic       w_unused;

    assign w_dx_op  = irDX[31:27];
    assign w_dx_rd  = irDX[26:22];
    assign w_dx_alu = irDX[6:2];
    assign w_fd_op  = irFD[31:27];
    assign w_fd_rd  = irFD[26:22];
    assign w_fd_rs  = irFD[21:17];
    assign w_fd_rt  = irFD[16:12];
    assign w_unused = ^{irFD[11:0], irDX[21:7], irDX[1:0]};

    assign w_dx_mul = (w_dx_op == OP_R) && (w_dx_alu == ALU_MUL);
    assign w_dx_div = (w_dx_op == OP_R) && (w_dx_alu == ALU_DIV);
    assign w_dx_md  = w_dx_mul || w_dx_div;

    // A store reads its data register through the rd field, so it counts as a consumer.
    assign w_load_use = (w_dx_op == OP_LW) && (w_dx_rd != 5'd0) &&
                        ((w_fd_rs == w_dx_rd) ||
                         ((w_fd_op == OP_R)  && (w_fd_rt == w_dx_rd)) ||
                         ((w_fd_op == OP_SW) && (w_fd_rd == w_dx_rd)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_exc   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_exc   <= w_exc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_exc_nxt    = r_exc;
        pcEn         = 1'b1;
        fdEn         = 1'b1;
        dxEn         = 1'b1;
        dxNop        = 1'b0;
        xmNop        = 1'b0;
        ctrlMult     = 1'b0;
        ctrlDiv      = 1'b0;
        xmSelMultdiv = 1'b0;
        mdExc        = 1'b0;
        mdBusy       = 1'b0;
        // While reset is held every detector is gated off and the enables stay open.
        if (!reset) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_dx_md) begin
                        ctrlMult    = w_dx_mul;
                        ctrlDiv     = w_dx_div;
                        pcEn        = 1'b0;
                        fdEn        = 1'b0;
                        dxEn        = 1'b0;
                        xmNop       = 1'b1;
                        w_state_nxt = S_BUSY;
                        w_cnt_nxt   = '0;
                        w_exc_nxt   = 1'b0;
                    end else if (w_load_use) begin
                        pcEn  = 1'b0;
                        fdEn  = 1'b0;
                        dxNop = 1'b1;
                    end
                end
                S_BUSY: begin
                    pcEn      = 1'b0;
                    fdEn      = 1'b0;
                    dxEn      = 1'b0;
                    xmNop     = 1'b1;
                    mdBusy    = 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (multdivReady) begin
                        w_exc_nxt   = multdivException;
                        w_state_nxt = S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        w_exc_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    xmSelMultdiv = 1'b1;
                    mdExc        = r_exc;
                    w_state_nxt  = S_IDLE;
                    if (w_load_use) begin
                        pcEn  = 1'b0;
                        fdEn  = 1'b0;
                        dxNop = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed scenarios followed by
// random instruction/ready traffic, checked against a cycle-level reference model.
module tb_hazard_stall_ctrl;

    localparam int MAXC = 4;

    logic        clock;
    logic        reset;
    logic [31:0] irFD, irDX;
    logic        multdivReady, multdivException;
    logic        pcEn, fdEn, dxEn, dxNop, xmNop, ctrlMult, ctrlDiv, xmSelMultdiv, mdExc, mdBusy;

    hazard_stall_ctrl #(.MAX_MD_CYCLES(MAXC), .CNT_W(3)) dut (
        .clock(clock), .reset(reset), .irFD(irFD), .irDX(irDX),
        .multdivReady(multdivReady), .multdivException(multdivException),
        .pcEn(pcEn), .fdEn(fdEn), .dxEn(dxEn), .dxNop(dxNop), .xmNop(xmNop),
        .ctrlMult(ctrlMult), .ctrlDiv(ctrlDiv), .xmSelMultdiv(xmSelMultdiv),
        .mdExc(mdExc), .mdBusy(mdBusy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [9:0] exp_q[$];
    int         cyc_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;

    // Reference model: phase 0 = running normally, 1 = waiting on the unit, 2 = result release.
    int m_phase  = 0;
    int m_busy_n = 0;
    bit m_exc    = 1'b0;

    function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt, input int alu);
        logic [31:0] w;
        w = {op[4:0], rd[4:0], rs[4:0], rt[4:0], 5'd0, alu[4:0], 2'b00};
        return w;
    endfunction

    function automatic bit is_md(input logic [31:0] ir);
        return ir[31:27] == 5'd0 && (ir[6:2] == 5'd6 || ir[6:2] == 5'd7);
    endfunction

    function automatic bit hazard(input logic [31:0] fd, input logic [31:0] dx);
        int dst;
        dst = int'(dx[26:22]);
        if (dx[31:27] != 5'b01000 || dst == 0) return 1'b0;
        if (int'(fd[21:17]) == dst) return 1'b1;
        if (fd[31:27] == 5'b00000 && int'(fd[16:12]) == dst) return 1'b1;
        if (fd[31:27] == 5'b00111 && int'(fd[26:22]) == dst) return 1'b1;
        return 1'b0;
    endfunction

    // {pcEn,fdEn,dxEn,dxNop,xmNop,ctrlMult,ctrlDiv,xmSelMultdiv,mdExc,mdBusy}
    function automatic logic [9:0] model_out(input logic [31:0] fd, input logic [31:0] dx, input logic rs);
        bit pc = 1, f = 1, d = 1, dn = 0, xn = 0, cm = 0, cd = 0, sel = 0, ex = 0, bz = 0;
        if (!rs) begin
            if (m_phase == 1) begin
                pc = 0; f = 0; d = 0; xn = 1; bz = 1;
            end else if (m_phase == 0 && is_md(dx)) begin
                pc = 0; f = 0; d = 0; xn = 1;
                cm = (dx[6:2] == 5'd6);
                cd = (dx[6:2] == 5'd7);
            end else begin
                if (m_phase == 2) begin
                    sel = 1; ex = m_exc;
                end
                if (hazard(fd, dx)) begin
                    pc = 0; f = 0; dn = 1;
                end
            end
        end
        return {pc, f, d, dn, xn, cm, cd, sel, ex, bz};
    endfunction

    task automatic model_advance(input logic [31:0] dx, input logic rdy, input logic ex);
        if (m_phase == 0) begin
            if (is_md(dx)) begin
                m_phase  = 1;
                m_busy_n = 0;
            end
        end else if (m_phase == 1) begin
            m_busy_n++;
            if (rdy) begin
                m_exc   = ex;
                m_phase = 2;
            end else if (m_busy_n == MAXC) begin
                m_exc   = 1'b1;
                m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic step(input logic [31:0] fd, input logic [31:0] dx, input logic rdy, input logic ex, input logic rs);
        irFD = fd; irDX = dx; multdivReady = rdy; multdivException = ex; reset = rs;
        if (rs) begin
            m_phase = 0; m_busy_n = 0; m_exc = 1'b0;
        end
        exp_q.push_back(model_out(fd, dx, rs));
        cyc_q.push_back(cyc);
        @(posedge clock);
        if (!rs) model_advance(dx, rdy, ex);
        cyc++;
        #1;
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [9:0] e;
            logic [9:0] a;
            int         c;
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            a = {pcEn, fdEn, dxEn, dxNop, xmNop, ctrlMult, ctrlDiv, xmSelMultdiv, mdExc, mdBusy};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs cyc%0d: got %b expected %b (pc,fd,dx,dxNop,xmNop,mul,div,sel,exc,busy)", c, a, e);
            end
        end
    end

    function automatic logic [31:0] rand_ir();
        int r1, r2, r3;
        r1 = $urandom_range(0, 3); r2 = $urandom_range(0, 3); r3 = $urandom_range(0, 3);
        case ($urandom_range(0, 7))
            0: return mk(0, r1, r2, r3, 6);
            1: return mk(0, r1, r2, r3, 7);
            2, 3: return mk(8, r1, r2, 0, 0);
            4: return mk(7, r1, r2, 0, 0);
            5: return mk(0, r1, r2, r3, 0);
            6: return 32'h0;
            default: return $urandom();
        endcase
    endfunction

    logic [31:0] MUL, DIV, NOP, ADD, LW5;

    initial begin
        reset = 1'b1; irFD = '0; irDX = '0; multdivReady = 0; multdivException = 0;
        MUL = mk(0, 3, 1, 2, 6);
        DIV = mk(0, 4, 1, 2, 7);
        NOP = 32'h0;
        ADD = mk(0, 7, 1, 5, 0);
        LW5 = mk(8, 5, 2, 0, 0);
        @(posedge clock); #1;
        step(NOP, NOP, 0, 0, 1);
        step(NOP, MUL, 1, 0, 1);
        // mul, ready on the third BUSY cycle (ready in the start cycle is ignored)
        step(ADD, MUL, 1, 0, 0);
        step(ADD, MUL, 0, 0, 0);
        step(ADD, MUL, 0, 0, 0);
        step(ADD, MUL, 1, 0, 0);
        step(ADD, MUL, 0, 0, 0);
        step(NOP, NOP, 0, 0, 0);
        // div with exception
        step(NOP, DIV, 0, 0, 0);
        step(NOP, DIV, 0, 0, 0);
        step(NOP, DIV, 1, 1, 0);
        step(NOP, DIV, 0, 0, 0);
        step(NOP, NOP, 0, 0, 0);
        // timeout: ready never arrives
        step(NOP, MUL, 0, 0, 0);
        repeat (MAXC) step(NOP, MUL, 0, 0, 0);
        step(NOP, MUL, 0, 0, 0);
        step(NOP, NOP, 1, 0, 0);
        // load-use: rt match, bubble, rs match, r0 destination, store data
        step(ADD, LW5, 0, 0, 0);
        step(ADD, NOP, 0, 0, 0);
        step(mk(0, 7, 5, 1, 0), LW5, 0, 0, 0);
        step(mk(0, 7, 0, 1, 0), mk(8, 0, 2, 0, 0), 0, 0, 0);
        step(mk(7, 5, 2, 0, 0), LW5, 0, 0, 0);
        step(mk(7, 6, 2, 0, 0), LW5, 0, 0, 0);
        // back-to-back mul then div
        step(NOP, MUL, 0, 0, 0);
        step(NOP, MUL, 1, 0, 0);
        step(NOP, MUL, 0, 0, 0);
        step(NOP, DIV, 0, 0, 0);
        step(NOP, DIV, 0, 0, 0);
        step(NOP, DIV, 1, 0, 0);
        step(NOP, DIV, 0, 0, 0);
        step(NOP, NOP, 0, 0, 0);
        // reset while BUSY with count 2, then a stray ready
        step(NOP, MUL, 0, 0, 0);
        step(NOP, MUL, 0, 0, 0);
        step(NOP, MUL, 0, 0, 0);
        step(NOP, MUL, 0, 0, 1);
        step(NOP, NOP, 1, 1, 0);
        step(NOP, NOP, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(rand_ir(), rand_ir(), ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 60) == 0));
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
